// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
// Optional leading-zero suppression is enabled by defining SEG7_SCAN_LZS_EN.
module seg7_scan_ctrl #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned ON_CYC  = 1000,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned CW      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                load_req,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic [DIGITS-1:0]   load_dp,
    output logic                load_ack,
    output logic [3:0]          digit_code,
    output logic [DIGITS-1:0]   anode_n,
    output logic                dp_n,
    output logic                frame_start
);
    localparam int unsigned   IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_GAP, S_ON} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]      sdp_q, sdp_d;
    logic [3:0]             code_q, code_d;
    logic [DIGITS-1:0]      anode_q, anode_d;
    logic                   dpn_q, dpn_d;
    logic                   ack_q, ack_d;
    logic                   fs_q, fs_d;
    logic [DIGITS-1:0]      lit;

`ifdef SEG7_SCAN_LZS_EN
    logic lzs_seen;

    // Lit if this or any higher digit is nonzero, it carries a dp, or it is digit 0.
    // The shadow only changes at a frame boundary or in OFF, always at least one
    // GAP cycle before the next ON slot, so the registered copy is current here.
    always_comb begin
        lzs_seen = 1'b0;
        lit      = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lzs_seen = lzs_seen | (shadow_q[i] != 4'd0);
            lit[i]   = lzs_seen | sdp_q[i] | (i == 0);
        end
    end
`else
    assign lit = '1;
`endif

    // Next state plus registered-output values for the state being entered.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        ack_d    = 1'b0;
        fs_d     = 1'b0;
        code_d   = 4'd0;
        dpn_d    = 1'b1;
        anode_d  = '1;

        case (state_q)
            S_OFF: begin
                if (load_req) begin
                    shadow_d = load_data;
                    sdp_d    = load_dp;
                    ack_d    = 1'b1;
                end
                if (enable) begin
                    state_d = S_GAP;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (!enable) begin
                    state_d = S_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ON: begin
                if (!enable) begin
                    state_d = S_OFF;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == ON_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        fs_d  = 1'b1;
                        if (load_req) begin
                            shadow_d = load_data;
                            sdp_d    = load_dp;
                            ack_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_OFF;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        if (state_d != S_OFF) begin
            code_d = shadow_d[idx_d];
            dpn_d  = ~sdp_d[idx_d];
            if ((state_d == S_ON) && lit[idx_d]) begin
                anode_d = ~(DIGITS'(1) << idx_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            idx_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            sdp_q    <= '0;
            code_q   <= 4'd0;
            anode_q  <= '1;
            dpn_q    <= 1'b1;
            ack_q    <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            code_q   <= code_d;
            anode_q  <= anode_d;
            dpn_q    <= dpn_d;
            ack_q    <= ack_d;
            fs_q     <= fs_d;
        end
    end

    assign load_ack    = ack_q;
    assign digit_code  = code_q;
    assign anode_n     = anode_q;
    assign dp_n        = dpn_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: vector table, directed corner cases and
// randomized traffic against a position-in-frame reference model.
module tb_seg7_scan_ctrl;
    localparam int unsigned DIGITS  = 4;
    localparam int unsigned ON_CYC  = 4;
    localparam int unsigned GAP_CYC = 2;
    localparam int unsigned CW      = 16;
    localparam int          SLOT    = GAP_CYC + ON_CYC;
    localparam int          FRAME   = DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load_req;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        load_ack;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;
    logic        dp_n;
    logic        frame_start;

    int tests = 0;
    int fails = 0;

    seg7_scan_ctrl #(.DIGITS(DIGITS), .ON_CYC(ON_CYC), .GAP_CYC(GAP_CYC), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load_req(load_req),
        .load_data(load_data), .load_dp(load_dp), .load_ack(load_ack),
        .digit_code(digit_code), .anode_n(anode_n), .dp_n(dp_n), .frame_start(frame_start)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference model: scanning flag, position within the frame, shadow value.
    bit          m_on;
    int          m_t;
    logic [15:0] m_sh;
    logic [3:0]  m_dp;
    bit          m_ack;
    bit          m_fs;

    function automatic bit m_lit(int d);
`ifdef SEG7_SCAN_LZS_EN
        return (d == 0) || (m_dp[d] == 1'b1) || ((m_sh >> (4 * d)) != 16'd0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [3:0] exp_code();
        if (!m_on) return 4'd0;
        return 4'((m_sh >> (4 * (m_t / SLOT))) & 16'hF);
    endfunction

    function automatic logic [3:0] exp_an();
        int d;
        if (!m_on) return 4'hF;
        d = m_t / SLOT;
        if ((m_t % SLOT) < GAP_CYC || !m_lit(d)) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic exp_dpn();
        if (!m_on) return 1'b1;
        return ~m_dp[m_t / SLOT];
    endfunction

    task automatic model_reset();
        m_on = 0; m_t = 0; m_sh = 16'd0; m_dp = 4'd0; m_ack = 0; m_fs = 0;
    endtask

    task automatic model_step();
        m_ack = 0;
        m_fs  = 0;
        if (!m_on) begin
            if (load_req) begin
                m_sh = load_data; m_dp = load_dp; m_ack = 1;
            end
            if (enable) begin
                m_on = 1; m_t = 0;
            end
        end else if (!enable) begin
            m_on = 0;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0;
                m_fs = 1;
                if (load_req) begin
                    m_sh = load_data; m_dp = load_dp; m_ack = 1;
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        tests++;
        if (anode_n !== exp_an() || digit_code !== exp_code() || dp_n !== exp_dpn()
            || load_ack !== m_ack || frame_start !== m_fs) begin
            fails++;
            $display("FAIL model t=%0d: anode_n=%b code=%h dp_n=%b ack=%b fs=%b, expected anode_n=%b code=%h dp_n=%b ack=%b fs=%b",
                     m_t, anode_n, digit_code, dp_n, load_ack, frame_start,
                     exp_an(), exp_code(), exp_dpn(), m_ack, m_fs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk_model();
    endtask

    // Go dark, load a value in OFF, then restart scanning (model ends at t=0).
    task automatic load_and_start(input logic [15:0] data, input logic [3:0] dp);
        enable = 1'b0;
        tick();
        load_req = 1'b1; load_data = data; load_dp = dp;
        tick();
        load_req = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    // From frame position 0, run the frame and record anode/code at each digit's first ON cycle.
    task automatic probe_frame(output logic [15:0] an_pack, output logic [15:0] code_pack);
        an_pack = 16'h0; code_pack = 16'h0;
        for (int t = 1; t < FRAME; t++) begin
            tick();
            if ((t % SLOT) == GAP_CYC) begin
                an_pack[4 * (t / SLOT) +: 4]   = anode_n;
                code_pack[4 * (t / SLOT) +: 4] = digit_code;
            end
        end
    endtask

    typedef struct {
        logic        en;
        logic        req;
        logic [15:0] data;
        logic [3:0]  an;
        logic [3:0]  code;
        logic        ack;
        logic        fs;
    } vec_t;

    vec_t vt[2 * FRAME + 1];

    initial begin
        logic [15:0] an_pack, code_pack, nv;
        logic [3:0]  last_code;
        bit          got, early_ack;
        int          acks;

        vt[0].en = 1'b0; vt[0].req = 1'b1; vt[0].data = 16'h1234;
        vt[0].an = 4'hF; vt[0].code = 4'd0; vt[0].ack = 1'b1; vt[0].fs = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            vt[k + 1].en   = 1'b1;
            vt[k + 1].req  = 1'b0;
            vt[k + 1].data = 16'h1234;
            vt[k + 1].an   = ((k % SLOT) < GAP_CYC) ? 4'hF : ~(4'b0001 << ((k % FRAME) / SLOT));
            vt[k + 1].code = 4'(4 - (k % FRAME) / SLOT);
            vt[k + 1].ack  = 1'b0;
            vt[k + 1].fs   = (k == FRAME);
        end

        // Asynchronous reset with no clock running.
        rst_n = 1'b1; enable = 1'b0; load_req = 1'b0; load_data = 16'h0; load_dp = 4'h0;
        #3 rst_n = 1'b0;
        #2;
        chk("reset_anode_n", 32'(anode_n), 32'hF);
        chk("reset_dp_n", 32'(dp_n), 32'h1);
        chk("reset_code", 32'(digit_code), 32'h0);
        chk("reset_ack", 32'(load_ack), 32'h0);
        chk("reset_fs", 32'(frame_start), 32'h0);
        model_reset();
        #5 rst_n = 1'b1;
        clk_en = 1'b1;

        // Load 1234 in OFF, then two full frames.
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            enable = vt[i].en; load_req = vt[i].req; load_data = vt[i].data; load_dp = 4'h0;
            tick();
            chk($sformatf("vec%0d", i), {anode_n, digit_code, 3'b0, load_ack, 3'b0, frame_start},
                {vt[i].an, vt[i].code, 3'b0, vt[i].ack, 3'b0, vt[i].fs});
        end

        // Mid-frame load request waits for the boundary.
        tick();
        repeat (4) tick();
        load_req = 1'b1; load_data = 16'hABCD;
        got = 0; early_ack = 0; last_code = 4'd0;
        for (int c = 0; c < FRAME + 2 && !got; c++) begin
            tick();
            if (frame_start) got = 1;
            else begin
                if (load_ack) early_ack = 1;
                last_code = digit_code;
            end
        end
        chk("midload_fs_seen", 32'(got), 32'h1);
        chk("midload_ack_with_fs", 32'(load_ack), 32'h1);
        chk("midload_no_early_ack", 32'(early_ack), 32'h0);
        chk("midload_old_tail", 32'(last_code), 32'h1);
        load_req = 1'b0;
        nv = 16'hABCD;
        for (int t = 1; t < FRAME; t++) begin
            tick();
            if ((t % SLOT) == GAP_CYC)
                chk($sformatf("newframe_d%0d", t / SLOT), 32'(digit_code), 32'(nv[4 * (t / SLOT) +: 4]));
        end

        // Cancelled request: three cycles high mid-frame, then dropped.
        tick();
        repeat (3) tick();
        load_req = 1'b1; load_data = 16'h5678;
        repeat (3) tick();
        load_req = 1'b0;
        acks = 0;
        repeat (2 * FRAME) begin
            tick();
            if (load_ack) acks++;
        end
        chk("cancel_no_ack", 32'(acks), 32'h0);
        chk("cancel_shadow_kept", 32'(digit_code), 32'hC);

        // Enable drop during the digit-2 ON slot, then re-enable.
        repeat (8) tick();
        chk("dig2_on", 32'(anode_n), 32'hB);
        enable = 1'b0;
        tick();
        chk("endrop_dark", 32'(anode_n), 32'hF);
        tick();
        enable = 1'b1;
        tick();
        chk("reen_gap_anode", 32'(anode_n), 32'hF);
        chk("reen_gap_code", 32'(digit_code), 32'hD);
        tick();
        tick();
        chk("reen_digit0", 32'(anode_n), 32'hE);

        // Reset in the middle of an ON slot turns the anodes off at once.
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_anode", 32'(anode_n), 32'hF);
        chk("midreset_code", 32'(digit_code), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Leading-zero suppression cases.
        load_and_start(16'h0050, 4'h0);
        probe_frame(an_pack, code_pack);
`ifdef SEG7_SCAN_LZS_EN
        chk("lzs_0050_an", 32'(an_pack), 32'hFFDE);
`else
        chk("lzs_0050_an", 32'(an_pack), 32'h7BDE);
`endif
        chk("lzs_0050_code", 32'(code_pack), 32'h0050);

        load_and_start(16'h0000, 4'h0);
        probe_frame(an_pack, code_pack);
`ifdef SEG7_SCAN_LZS_EN
        chk("lzs_zero_an", 32'(an_pack), 32'hFFFE);
`else
        chk("lzs_zero_an", 32'(an_pack), 32'h7BDE);
`endif

        load_and_start(16'h0000, 4'h8);
        probe_frame(an_pack, code_pack);
`ifdef SEG7_SCAN_LZS_EN
        chk("lzs_dp3_an", 32'(an_pack), 32'h7FFE);
`else
        chk("lzs_dp3_an", 32'(an_pack), 32'h7BDE);
`endif

        // Randomized traffic: enable toggles, held / cancelled / acked requests.
        for (int c = 0; c < 1500; c++) begin
            if (load_req && load_ack) load_req = 1'b0;
            else if (load_req && $urandom_range(0, 39) == 0) load_req = 1'b0;
            else if (!load_req && $urandom_range(0, 19) == 0) begin
                load_req  = 1'b1;
                load_data = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                load_dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
